// File: rtl/pipe_countup_dp.sv
// pipe_countup_dp
//   Four-stage pipelined count-up datapath. Each token issued by stage 0
//   carries a sampled step value through operand latch (S1), add (S2) and
//   write-back (S3) into an accumulator. It sits downstream of a sequencing
//   FSM whose 4-bit state drives en[3:0] one-to-one.
//
// Parameters
//   W   accumulator / count width
//   SW  step input width (SW <= W)
//
// Ports
//   CLK     in   clock, all state on rising edge
//   RSTN    in   asynchronous active-low reset
//   en      in   per-stage enables, en[i] advances stage i
//   step    in   increment value, sampled when stage 0 issues
//   clr     in   synchronous clear, priority over en
//   count   out  accumulator value
//   ovf     out  sticky overflow flag
//   wb      out  registered write-back pulse
//   issued  out  wrapping count of issued tokens
//   busy    out  OR of all stage valids
module pipe_countup_dp #(
  parameter int W  = 16,
  parameter int SW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [3:0]    en,
  input  logic [SW-1:0] step,
  input  logic          clr,
  output logic [W-1:0]  count,
  output logic          ovf,
  output logic          wb,
  output logic [7:0]    issued,
  output logic          busy
);

  logic          s0V_q, s0V_d;
  logic [SW-1:0] s0Step_q, s0Step_d;
  logic          s1V_q, s1V_d;
  logic [SW-1:0] s1Step_q, s1Step_d;
  logic          s2V_q, s2V_d;
  logic [W-1:0]  s2Sum_q, s2Sum_d;
  logic          s2C_q, s2C_d;
  logic          s3V_q, s3V_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic          wb_q, wb_d;
  logic [7:0]    issued_q, issued_d;

  logic [W-1:0]  addBase;
  logic [W:0]    addRes;

  // S2 holds the newest not-yet-written sum whenever s2V_q is set, so it is
  // the correct base for the next add; otherwise the accumulator is current.
  assign addBase = s2V_q ? s2Sum_q : acc_q;
  assign addRes  = {1'b0, addBase} + {{(W + 1 - SW){1'b0}}, s1Step_q};

  // Next-state logic for every stage. A stage whose enable is low is
  // invalidated when the stage after it advances (so the token is not
  // consumed twice), otherwise it simply holds.
  always_comb begin
    s0V_d    = s0V_q;
    s0Step_d = s0Step_q;
    s1V_d    = s1V_q;
    s1Step_d = s1Step_q;
    s2V_d    = s2V_q;
    s2Sum_d  = s2Sum_q;
    s2C_d    = s2C_q;
    s3V_d    = s3V_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    wb_d     = 1'b0;
    issued_d = issued_q;

    if (clr) begin
      s0V_d    = 1'b0;
      s0Step_d = '0;
      s1V_d    = 1'b0;
      s1Step_d = '0;
      s2V_d    = 1'b0;
      s2Sum_d  = '0;
      s2C_d    = 1'b0;
      s3V_d    = 1'b0;
      acc_d    = '0;
      ovf_d    = 1'b0;
      issued_d = '0;
    end else begin
      if (en[0]) begin
        s0V_d    = 1'b1;
        s0Step_d = step;
        issued_d = issued_q + 8'd1;
      end else if (en[1]) begin
        s0V_d = 1'b0;
      end

      if (en[1]) begin
        s1V_d    = s0V_q;
        s1Step_d = s0Step_q;
      end else if (en[2]) begin
        s1V_d = 1'b0;
      end

      if (en[2]) begin
        if (s1V_q) begin
          s2V_d   = 1'b1;
          s2Sum_d = addRes[W-1:0];
          s2C_d   = addRes[W];
        end else begin
          s2V_d = 1'b0;
        end
      end else if (en[3]) begin
        s2V_d = 1'b0;
      end

      s3V_d = en[3] & s2V_q;
      if (en[3] && s2V_q) begin
        acc_d = s2Sum_q;
        ovf_d = ovf_q | s2C_q;
        wb_d  = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s0V_q    <= 1'b0;
      s0Step_q <= '0;
      s1V_q    <= 1'b0;
      s1Step_q <= '0;
      s2V_q    <= 1'b0;
      s2Sum_q  <= '0;
      s2C_q    <= 1'b0;
      s3V_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      wb_q     <= 1'b0;
      issued_q <= '0;
    end else begin
      s0V_q    <= s0V_d;
      s0Step_q <= s0Step_d;
      s1V_q    <= s1V_d;
      s1Step_q <= s1Step_d;
      s2V_q    <= s2V_d;
      s2Sum_q  <= s2Sum_d;
      s2C_q    <= s2C_d;
      s3V_q    <= s3V_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      wb_q     <= wb_d;
      issued_q <= issued_d;
    end
  end

  assign count  = acc_q;
  assign ovf    = ovf_q;
  assign wb     = wb_q;
  assign issued = issued_q;
  assign busy   = s0V_q | s1V_q | s2V_q | s3V_q;

endmodule

// File: tb/tb_pipe_countup_dp.sv
// tb_pipe_countup_dp
//   Scoreboard bench for pipe_countup_dp. The driver computes, for each
//   issued token, the running total the accumulator must show when that
//   token is written back and queues it; a monitor pops one entry per wb
//   pulse and compares count and ovf.
module tb_pipe_countup_dp;

  logic        CLK;
  logic        RSTN;
  logic [3:0]  en;
  logic [7:0]  step;
  logic        clr;
  logic [15:0] count;
  logic        ovf;
  logic        wb;
  logic [7:0]  issued;
  logic        busy;

  typedef struct {
    logic [15:0] cnt;
    logic        ov;
  } exp_t;

  exp_t   expQ[$];
  longint total;
  int     issuedExp;
  int     checks;
  int     failures;
  int     wbSeen;
  int     cycleCnt;
  int     firstWbCycle;

  pipe_countup_dp #(.W(16), .SW(8)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .en     (en),
    .step   (step),
    .clr    (clr),
    .count  (count),
    .ovf    (ovf),
    .wb     (wb),
    .issued (issued),
    .busy   (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drop every token the model still expects, as reset or clr would.
  task automatic flushModel();
    expQ.delete();
    total     = 0;
    issuedExp = 0;
  endtask

  // One clock cycle of stimulus. The model works purely on the token stream:
  // every issue adds its step to the running total, and that total (mod 2^16,
  // with overflow once it has ever reached 2^16) is what the write-back of
  // the same token must show.
  task automatic applyStimulus(input logic [3:0] e, input logic [7:0] s, input logic c);
    exp_t item;
    @(negedge CLK);
    #1;
    en   = e;
    step = s;
    clr  = c;
    if (c) begin
      flushModel();
    end else if (e[0]) begin
      total     = total + longint'(s);
      issuedExp = (issuedExp + 1) % 256;
      item.cnt  = 16'(total % 65536);
      item.ov   = (total >= 65536);
      expQ.push_back(item);
    end
    @(posedge CLK);
    cycleCnt++;
  endtask

  // Full legal fill/hold/drain sequence. mode 0: constant step; mode 1:
  // base, base+1, ... on successive issues; mode 2: random steps.
  task automatic runLegal(input int n, input int mode, input logic [7:0] base);
    logic [3:0] seqE[$];
    logic [7:0] s;
    int         idx;
    seqE = {4'b0001, 4'b0011, 4'b0111};
    repeat (n) seqE.push_back(4'b1111);
    seqE.push_back(4'b1110);
    seqE.push_back(4'b1100);
    seqE.push_back(4'b1000);
    seqE.push_back(4'b0000);
    idx = 0;
    foreach (seqE[i]) begin
      s = 8'd0;
      if (seqE[i][0]) begin
        if (mode == 0) s = base;
        else if (mode == 1) s = base + 8'(idx);
        else s = 8'($urandom_range(0, 255));
        idx++;
      end
      applyStimulus(seqE[i], s, 1'b0);
    end
  endtask

  task automatic checkFinal(input string tag);
    #1;
    checkOutput({tag, "_count"}, count, total % 65536);
    checkOutput({tag, "_ovf"}, ovf, (total >= 65536) ? 1 : 0);
    checkOutput({tag, "_issued"}, issued, issuedExp);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_pending"}, expQ.size(), 0);
  endtask

  // Monitor: every write-back pulse must match the oldest queued token.
  always @(negedge CLK) begin
    if (wb) begin
      wbSeen++;
      if (firstWbCycle < 0) firstWbCycle = cycleCnt;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wbUnexpected actual=1 expected=0 count=%0d", count);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("wbCount", count, e.cnt);
        checkOutput("wbOvf", ovf, e.ov);
      end
    end
  end

  initial begin
    int start;
    checks       = 0;
    failures     = 0;
    wbSeen       = 0;
    cycleCnt     = 0;
    firstWbCycle = -1;
    flushModel();
    en   = 4'b1111;
    step = 8'd0;
    clr  = 1'b0;
    RSTN = 1'b1;

    // Reset asserted with all enables high: outputs clear immediately.
    #1 RSTN = 1'b0;
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_wb", wb, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_issued", issued, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    en = 4'b0000;
    #2 RSTN = 1'b1;
    repeat (10) applyStimulus(4'b0000, 8'($urandom_range(0, 255)), 1'b0);
    #1;
    checkOutput("idle_count", count, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_issued", issued, 0);
    checkOutput("idle_wb", wb, 0);
    checkOutput("idle_wbSeen", wbSeen, 0);

    // Basic run: step 3, N=5.
    wbSeen       = 0;
    firstWbCycle = -1;
    start        = cycleCnt;
    runLegal(5, 0, 8'd3);
    checkFinal("basic");
    checkOutput("basic_countLit", count, 24);
    checkOutput("basic_issuedLit", issued, 8);
    checkOutput("basic_wbPulses", wbSeen, 8);
    checkOutput("basic_firstWbEdge", firstWbCycle - start, 4);

    // Varying step 1..5, N=2.
    applyStimulus(4'b0000, 8'd0, 1'b1);
    runLegal(2, 1, 8'd1);
    checkFinal("vary");
    checkOutput("vary_countLit", count, 15);
    checkOutput("vary_ovfLit", ovf, 0);

    // Just below and just past the wrap point.
    applyStimulus(4'b0000, 8'd0, 1'b1);
    runLegal(254, 0, 8'd255);
    checkFinal("ovf257");
    checkOutput("ovf257_countLit", count, 65535);
    checkOutput("ovf257_ovfLit", ovf, 0);
    applyStimulus(4'b0000, 8'd0, 1'b1);
    runLegal(255, 0, 8'd255);
    checkFinal("ovf258");
    checkOutput("ovf258_countLit", count, 254);
    checkOutput("ovf258_ovfLit", ovf, 1);

    // Clear in the middle of a hold phase.
    applyStimulus(4'b0000, 8'd0, 1'b1);
    applyStimulus(4'b0001, 8'd3, 1'b0);
    applyStimulus(4'b0011, 8'd3, 1'b0);
    applyStimulus(4'b0111, 8'd3, 1'b0);
    repeat (3) applyStimulus(4'b1111, 8'd3, 1'b0);
    #1 checkOutput("clr_preCount", count, 9);
    applyStimulus(4'b1111, 8'd3, 1'b1);
    #1;
    checkOutput("clr_count", count, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_issued", issued, 0);
    repeat (2) applyStimulus(4'b1111, 8'd3, 1'b0);
    applyStimulus(4'b1110, 8'd3, 1'b0);
    applyStimulus(4'b1100, 8'd3, 1'b0);
    applyStimulus(4'b1000, 8'd3, 1'b0);
    applyStimulus(4'b0000, 8'd3, 1'b0);
    checkFinal("clrRun");
    checkOutput("clrRun_countLit", count, 6);

    // Asynchronous reset between edges during a hold phase.
    applyStimulus(4'b0000, 8'd0, 1'b1);
    applyStimulus(4'b0001, 8'd3, 1'b0);
    applyStimulus(4'b0011, 8'd3, 1'b0);
    applyStimulus(4'b0111, 8'd3, 1'b0);
    repeat (2) applyStimulus(4'b1111, 8'd3, 1'b0);
    #2 RSTN = 1'b0;
    #1;
    checkOutput("arst_count", count, 0);
    checkOutput("arst_ovf", ovf, 0);
    checkOutput("arst_wb", wb, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_issued", issued, 0);
    flushModel();
    en = 4'b0000;
    @(negedge CLK);
    #2 RSTN = 1'b1;
    wbSeen = 0;
    runLegal(0, 0, 8'd7);
    checkFinal("arstRun");
    checkOutput("arstRun_countLit", count, 21);
    checkOutput("arstRun_wbPulses", wbSeen, 3);

    // Random legal runs accumulating without clears in between.
    applyStimulus(4'b0000, 8'd0, 1'b1);
    for (int r = 0; r < 8; r++) begin
      runLegal($urandom_range(0, 20), 2, 8'd0);
      checkFinal("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
